// File: rtl/adder_fp_8.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : adder_fp_8                                                      |
// | Brief    : FP8 (1-4-3, bias 7) adder, RNE rounding, one registered stage   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module adder_fp_8 (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] out
);

    localparam logic [7:0] c_CANON_NAN = 8'h7C;
    localparam logic [6:0] c_INF_MAG   = 7'h78;

    logic       w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic       w_swap, w_sub;
    logic [7:0] w_l, w_s;
    logic [3:0] w_el, w_es, w_ml, w_ms, w_diff;
    logic [13:0] w_sh;
    logic [6:0] w_l7, w_s7;
    logic [7:0] w_sum8;
    logic [2:0] w_lz;
    logic [3:0] w_shamt;
    logic [6:0] w_norm;
    logic [4:0] w_en;
    logic       w_rnd;
    logic [4:0] w_m5;
    logic [4:0] w_ef;
    logic [2:0] w_mant;
    logic [7:0] out_d, out_q;

    assign w_a_nan = (a[6:3] == 4'hF) && (a[2:0] != 3'd0);
    assign w_b_nan = (b[6:3] == 4'hF) && (b[2:0] != 3'd0);
    assign w_a_inf = (a[6:3] == 4'hF) && (a[2:0] == 3'd0);
    assign w_b_inf = (b[6:3] == 4'hF) && (b[2:0] == 3'd0);

    // Larger magnitude goes first; the 7-bit encoding orders magnitudes directly.
    assign w_swap = (b[6:0] > a[6:0]);
    assign w_l    = w_swap ? b : a;
    assign w_s    = w_swap ? a : b;
    assign w_sub  = w_l[7] ^ w_s[7];

    assign w_el   = (w_l[6:3] == 4'd0) ? 4'd1 : w_l[6:3];
    assign w_es   = (w_s[6:3] == 4'd0) ? 4'd1 : w_s[6:3];
    assign w_ml   = {|w_l[6:3], w_l[2:0]};
    assign w_ms   = {|w_s[6:3], w_s[2:0]};
    assign w_diff = w_el - w_es;

    // Significand followed by guard, round and sticky positions.
    assign w_l7 = {w_ml, 3'b000};
    assign w_sh = {w_ms, 10'd0} >> w_diff;
    assign w_s7 = (w_diff >= 4'd7) ? {6'd0, |w_ms}
                                   : {w_sh[13:8], w_sh[7] | (|w_sh[6:0])};

    assign w_sum8 = w_sub ? ({1'b0, w_l7} - {1'b0, w_s7})
                          : ({1'b0, w_l7} + {1'b0, w_s7});

    always_comb begin
        w_lz = 3'd7;
        for (int i = 0; i <= 6; i++) begin
            if (w_sum8[i]) w_lz = 3'(6 - i);
        end
    end

    // Left shift stops at the minimum exponent so tiny results stay subnormal.
    assign w_shamt = ({1'b0, w_lz} > (w_el - 4'd1)) ? (w_el - 4'd1) : {1'b0, w_lz};

    always_comb begin
        w_norm = 7'd0;
        w_en   = 5'd0;
        if (w_sum8[7]) begin
            w_norm = {w_sum8[7:2], w_sum8[1] | w_sum8[0]};
            w_en   = {1'b0, w_el} + 5'd1;
        end else begin
            w_norm = w_sum8[6:0] << w_shamt;
            w_en   = {1'b0, w_el} - {1'b0, w_shamt};
        end
    end

    assign w_rnd = w_norm[2] & (w_norm[3] | w_norm[1] | w_norm[0]);
    assign w_m5  = {1'b0, w_norm[6:3]} + {4'd0, w_rnd};

    always_comb begin
        w_ef   = 5'd0;
        w_mant = 3'd0;
        if (w_m5[4]) begin
            w_ef   = w_en + 5'd1;
            w_mant = 3'd0;
        end else begin
            w_ef   = w_m5[3] ? w_en : 5'd0;
            w_mant = w_m5[2:0];
        end
    end

    always_comb begin
        out_d = 8'h00;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (a[7] != b[7]))) begin
            out_d = c_CANON_NAN;
        end else if (w_a_inf) begin
            out_d = {a[7], c_INF_MAG};
        end else if (w_b_inf) begin
            out_d = {b[7], c_INF_MAG};
        end else if (w_sum8 == 8'd0) begin
            out_d = {a[7] & b[7], 7'd0};
        end else if (w_ef >= 5'd15) begin
            out_d = {w_l[7], c_INF_MAG};
        end else begin
            out_d = {w_l[7], w_ef[3:0], w_mant};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q <= 8'h00;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_fp_8.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_adder_fp_8                                                   |
// | Brief    : Self-checking bench for adder_fp_8 against an exact-value model |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_adder_fp_8;

    logic       clk;
    logic       reset;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;

    int checks   = 0;
    int failures = 0;

    adder_fp_8 dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Magnitude in units of 2^-9, the smallest subnormal step.
    function automatic int mag_units(input logic [6:0] m);
        int e;
        int f;
        e = int'(m[6:3]);
        f = int'(m[2:0]);
        if (e == 0) return f;
        return (8 + f) << (e - 1);
    endfunction

    // Exact sum, then nearest representable magnitude (0x78 stands for 256, i.e. overflow).
    function automatic logic [7:0] ref_add(input logic [7:0] x, input logic [7:0] y);
        logic       xn, yn, xi, yi;
        int         sum, mag, d, bestd;
        logic [6:0] cc, best;
        xn = (x[6:3] == 4'hF) && (x[2:0] != 3'd0);
        yn = (y[6:3] == 4'hF) && (y[2:0] != 3'd0);
        xi = (x[6:3] == 4'hF) && (x[2:0] == 3'd0);
        yi = (y[6:3] == 4'hF) && (y[2:0] == 3'd0);
        if (xn || yn || (xi && yi && (x[7] != y[7]))) return 8'h7C;
        if (xi) return x;
        if (yi) return y;
        sum = (x[7] ? -mag_units(x[6:0]) : mag_units(x[6:0]))
            + (y[7] ? -mag_units(y[6:0]) : mag_units(y[6:0]));
        if (sum == 0) return {x[7] & y[7], 7'd0};
        mag   = (sum < 0) ? -sum : sum;
        best  = 7'd0;
        bestd = 32'h7FFFFFFF;
        for (int c = 0; c <= 120; c++) begin
            cc = 7'(c);
            d  = mag_units(cc) - mag;
            if (d < 0) d = -d;
            if ((d < bestd) || ((d == bestd) && (cc[0] == 1'b0))) begin
                bestd = d;
                best  = cc;
            end
        end
        return {sum < 0, best};
    endfunction

    task automatic check(input logic [7:0] expv, input string tag);
        checks++;
        assert (out === expv)
        else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, out, expv);
        end
    endtask

    task automatic apply(input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] expv, input string tag);
        @(negedge clk);
        a = x;
        b = y;
        @(posedge clk);
        #1;
        check(expv, tag);
    endtask

    logic [7:0] da [16] = '{8'h38, 8'h3C, 8'h38, 8'h80, 8'h01, 8'h38, 8'h38, 8'h39,
                            8'h77, 8'h78, 8'h79, 8'hF8, 8'h00, 8'h07, 8'hB8, 8'h78};
    logic [7:0] db [16] = '{8'h38, 8'h30, 8'hB8, 8'h80, 8'h01, 8'h00, 8'h18, 8'h18,
                            8'h77, 8'hF8, 8'h38, 8'h40, 8'h80, 8'h01, 8'h98, 8'h78};
    logic [7:0] de [16] = '{8'h40, 8'h40, 8'h00, 8'h80, 8'h02, 8'h38, 8'h38, 8'h3A,
                            8'h78, 8'h7C, 8'h7C, 8'hF8, 8'h00, 8'h08, 8'hB8, 8'h78};

    initial begin
        logic [7:0] x, y, e, prev;

        reset = 1'b0;
        a     = 8'h38;
        b     = 8'h38;
        #1;
        check(8'h00, "reset_init");
        @(posedge clk);
        #1;
        check(8'h00, "reset_hold_edge");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check(8'h40, "first_after_release");

        for (int i = 0; i < 16; i++) begin
            apply(da[i], db[i], de[i], $sformatf("directed%0d", i));
            apply(db[i], da[i], de[i], $sformatf("directed_swap%0d", i));
        end

        // Back-to-back stream; each pair is followed by its swap.
        prev = de[15];
        for (int i = 0; i < 150; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            for (int k = 0; k < 2; k++) begin
                e = (k == 0) ? ref_add(x, y) : ref_add(y, x);
                @(negedge clk);
                a = (k == 0) ? x : y;
                b = (k == 0) ? y : x;
                #1;
                check(prev, "stream_hold");
                @(posedge clk);
                #1;
                check(e, (k == 0) ? "stream_ab" : "stream_ba");
                prev = e;
            end
        end

        // Asynchronous reset in the middle of a cycle.
        apply(8'h40, 8'h40, 8'h48, "pre_reset");
        #2;
        reset = 1'b0;
        #1;
        check(8'h00, "async_reset");
        @(negedge clk);
        a = 8'h3C;
        b = 8'h30;
        @(posedge clk);
        #1;
        check(8'h00, "reset_held_mid");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check(8'h40, "release_mid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
